// File: rtl/udp_reg_responder.sv
// Register read/write responder for the sysRx/sysTx side of the UDP link port.
// Define UDP_RESP_STATS_EN to add the statPackets/statDrops counters.
module udp_reg_responder #(
  parameter int ADDR_WIDTH = 11,
  parameter int REG_AW     = 24,
  parameter int RD_LATENCY = 2
) (
  input  logic              sysClk,
  input  logic              sysReset_n,
  output logic              sysRxEnable,
  input  logic              sysRxValid,
  input  logic              sysRxLast,
  input  logic [1:0]        sysByteIndex,
  input  logic [31:0]       sysRxData,
  output logic              sysRxReady,
  output logic              sysTxStrobe,
  output logic [31:0]       sysTxData,
  output logic              sysTxStart,
  input  logic              sysTxBusy,
  output logic [REG_AW-1:0] sysRegAddr,
  output logic [31:0]       sysRegWrData,
  output logic              sysRegStrobe,
  input  logic [31:0]       sysRegRdData
`ifdef UDP_RESP_STATS_EN
  ,
  output logic [15:0]       statPackets,
  output logic [15:0]       statDrops
`endif
);

  // state  | meaning
  // IDLE   | waiting for a packet while the transmitter is free
  // HDR    | accept and echo the header word
  // CMD_A  | accept the address word of a command pair
  // CMD_D  | accept the data word of a command pair
  // ACCESS | register bus write strobe or read latency wait
  // EMIT_A | write the echoed address word to the tx buffer
  // EMIT_D | write the reply data word to the tx buffer
  // START  | pulse sysTxStart when the reply is not empty
  // DRAIN  | swallow the rest of the packet without access

  typedef enum logic [3:0] {
    IDLE, HDR, CMD_A, CMD_D, ACCESS, EMIT_A, EMIT_D, START, DRAIN
  } stateT;

  localparam int          WCW       = ADDR_WIDTH - 1;
  localparam int unsigned CAP_WORDS = 2 ** (ADDR_WIDTH - 2);

  stateT             state, stateNxt;
  logic [WCW-1:0]    wcount, wcountNxt;
  logic [31:0]       aWord, aWordNxt;
  logic [31:0]       dWord, dWordNxt;
  logic              lastSeen, lastSeenNxt;
  logic              dropped, droppedNxt;
  logic [2:0]        timer, timerNxt;
  logic              txStrobeNxt;
  logic [31:0]       txDataNxt;
  logic              txStartNxt;
  logic [REG_AW-1:0] regAddrNxt;
  logic [31:0]       regWrDataNxt;
  logic              regStrobeNxt;

  logic              accept;
  logic              fullWord;
  logic              roomForPair;
  logic [ADDR_WIDTH:0] lastByteIdx;

  assign sysRxReady  = (state == HDR) || (state == CMD_A) ||
                       (state == CMD_D) || (state == DRAIN);
  assign accept      = sysRxValid && sysRxReady;
  assign fullWord    = (sysByteIndex == 2'd3);
  assign roomForPair = (32'(wcount) + 32'd2) <= CAP_WORDS;
  assign lastByteIdx = {wcount, 2'b00} - {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    stateNxt     = state;
    wcountNxt    = wcount;
    aWordNxt     = aWord;
    dWordNxt     = dWord;
    lastSeenNxt  = lastSeen;
    droppedNxt   = dropped;
    timerNxt     = timer;
    txStrobeNxt  = 1'b0;
    txDataNxt    = sysTxData;
    txStartNxt   = 1'b0;
    regAddrNxt   = sysRegAddr;
    regWrDataNxt = sysRegWrData;
    regStrobeNxt = 1'b0;

    case (state)
      IDLE: begin
        if (sysRxValid && !sysTxBusy) begin
          stateNxt    = HDR;
          wcountNxt   = '0;
          droppedNxt  = 1'b0;
          lastSeenNxt = 1'b0;
        end
      end
      HDR: begin
        if (accept) begin
          if (!fullWord) begin
            droppedNxt = 1'b1;
            stateNxt   = sysRxLast ? START : DRAIN;
          end else begin
            txStrobeNxt = 1'b1;
            txDataNxt   = sysRxData;
            wcountNxt   = WCW'(1);
            stateNxt    = sysRxLast ? START : CMD_A;
          end
        end
      end
      CMD_A: begin
        if (accept) begin
          if (!fullWord) droppedNxt = 1'b1;
          if (sysRxLast) begin
            stateNxt = START;
          end else if (!fullWord) begin
            stateNxt = DRAIN;
          end else begin
            aWordNxt = sysRxData;
            stateNxt = CMD_D;
          end
        end
      end
      CMD_D: begin
        if (accept) begin
          if (!fullWord || !roomForPair) begin
            droppedNxt = 1'b1;
            stateNxt   = sysRxLast ? START : DRAIN;
          end else begin
            dWordNxt    = sysRxData;
            lastSeenNxt = sysRxLast;
            regAddrNxt  = aWord[REG_AW-1:0];
            timerNxt    = 3'(RD_LATENCY);
            if (aWord[31]) begin
              regStrobeNxt = 1'b1;
              regWrDataNxt = sysRxData;
            end
            stateNxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        // reads count down from RD_LATENCY; capture on terminal count
        if (aWord[31]) begin
          stateNxt = EMIT_A;
        end else if (timer == 3'd0) begin
          dWordNxt = sysRegRdData;
          stateNxt = EMIT_A;
        end else begin
          timerNxt = timer - 3'd1;
        end
      end
      EMIT_A: begin
        txStrobeNxt = 1'b1;
        txDataNxt   = aWord;
        stateNxt    = EMIT_D;
      end
      EMIT_D: begin
        txStrobeNxt = 1'b1;
        txDataNxt   = dWord;
        wcountNxt   = wcount + WCW'(2);
        stateNxt    = lastSeen ? START : CMD_A;
      end
      START: begin
        if (wcount != '0) begin
          txStartNxt = 1'b1;
          txDataNxt  = 32'(lastByteIdx[ADDR_WIDTH-1:0]) << 16;
        end
        stateNxt = IDLE;
      end
      DRAIN: begin
        if (accept && sysRxLast) stateNxt = START;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state        <= IDLE;
      wcount       <= '0;
      aWord        <= '0;
      dWord        <= '0;
      lastSeen     <= 1'b0;
      dropped      <= 1'b0;
      timer        <= '0;
      sysRxEnable  <= 1'b0;
      sysTxStrobe  <= 1'b0;
      sysTxData    <= '0;
      sysTxStart   <= 1'b0;
      sysRegAddr   <= '0;
      sysRegWrData <= '0;
      sysRegStrobe <= 1'b0;
    end else begin
      state        <= stateNxt;
      wcount       <= wcountNxt;
      aWord        <= aWordNxt;
      dWord        <= dWordNxt;
      lastSeen     <= lastSeenNxt;
      dropped      <= droppedNxt;
      timer        <= timerNxt;
      sysRxEnable  <= 1'b1;
      sysTxStrobe  <= txStrobeNxt;
      sysTxData    <= txDataNxt;
      sysTxStart   <= txStartNxt;
      sysRegAddr   <= regAddrNxt;
      sysRegWrData <= regWrDataNxt;
      sysRegStrobe <= regStrobeNxt;
    end
  end

`ifdef UDP_RESP_STATS_EN
  logic startEvt;
  logic dropEvt;

  assign startEvt = (state == START) && (wcount != '0);
  assign dropEvt  = (state == START) && dropped;

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      statPackets <= '0;
      statDrops   <= '0;
    end else begin
      if (startEvt) statPackets <= statPackets + 16'd1;
      if (dropEvt)  statDrops   <= statDrops + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_reg_responder.sv
// Bench for udp_reg_responder: directed and random packets against a packet-level
// reply model, with a register bus that returns data only in the exact latency cycle.
module tb_udp_reg_responder;
  localparam int AW  = 11;
  localparam int RAW = 24;
  localparam int RDL = 2;
  localparam int CAP = 512;

  logic           sysClk = 1'b0;
  logic           sysReset_n;
  logic           sysRxEnable;
  logic           sysRxValid;
  logic           sysRxLast;
  logic [1:0]     sysByteIndex;
  logic [31:0]    sysRxData;
  logic           sysRxReady;
  logic           sysTxStrobe;
  logic [31:0]    sysTxData;
  logic           sysTxStart;
  logic           sysTxBusy;
  logic [RAW-1:0] sysRegAddr;
  logic [31:0]    sysRegWrData;
  logic           sysRegStrobe;
  logic [31:0]    sysRegRdData;
`ifdef UDP_RESP_STATS_EN
  logic [15:0]    statPackets;
  logic [15:0]    statDrops;
`endif

  udp_reg_responder #(.ADDR_WIDTH(AW), .REG_AW(RAW), .RD_LATENCY(RDL)) dut (
    .sysClk(sysClk), .sysReset_n(sysReset_n), .sysRxEnable(sysRxEnable),
    .sysRxValid(sysRxValid), .sysRxLast(sysRxLast), .sysByteIndex(sysByteIndex),
    .sysRxData(sysRxData), .sysRxReady(sysRxReady), .sysTxStrobe(sysTxStrobe),
    .sysTxData(sysTxData), .sysTxStart(sysTxStart), .sysTxBusy(sysTxBusy),
    .sysRegAddr(sysRegAddr), .sysRegWrData(sysRegWrData), .sysRegStrobe(sysRegStrobe),
    .sysRegRdData(sysRegRdData)
`ifdef UDP_RESP_STATS_EN
    , .statPackets(statPackets), .statDrops(statDrops)
`endif
  );

  always #5 sysClk = ~sysClk;

  int passCount = 0;
  int totalCount = 0;
  int busyViol = 0;
  int expPackets = 0;
  int expDrops = 0;

  logic [31:0] txQ[$];
  logic [31:0] startQ[$];
  logic [55:0] wrQ[$];
  logic [31:0] expTx[$];
  logic [55:0] expWr[$];
  logic        expDrop;
  logic [31:0] pw[$];
  logic [1:0]  pb[$];
  logic        curIsReadD = 1'b0;

  function automatic logic [31:0] rdFn(input logic [23:0] a);
    return {a[7:0], a} ^ 32'hA5C3_0F96;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // output monitor
  initial forever begin
    @(negedge sysClk);
    if (sysTxStrobe) txQ.push_back(sysTxData);
    if (sysTxStart) startQ.push_back(sysTxData);
    if (sysRegStrobe) wrQ.push_back({sysRegAddr, sysRegWrData});
    if ((sysTxStrobe || sysTxStart) && sysTxBusy) busyViol++;
  end

  // register bus: read data valid only RDL cycles after the address appears
  initial begin
    logic accRd;
    int   rdCnt;
    rdCnt = -1;
    sysRegRdData = '0;
    forever begin
      @(negedge sysClk);
      accRd = sysRxValid && sysRxReady && curIsReadD;
      @(posedge sysClk);
      #1;
      if (accRd) rdCnt = RDL;
      else if (rdCnt >= 0) rdCnt--;
      sysRegRdData = (rdCnt == 0) ? rdFn(sysRegAddr) : $urandom();
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge sysClk);
    #1;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic [1:0] bi, input logic last,
                          input logic isRdD);
    int n;
    sysRxValid = 1'b1; sysRxData = d; sysByteIndex = bi; sysRxLast = last;
    curIsReadD = isRdD;
    n = 0;
    do begin
      @(negedge sysClk);
      n++;
    end while (!sysRxReady && n < 300);
    if (!sysRxReady) check("accept_timeout", sysRxReady, 1);
    @(posedge sysClk);
    #1;
    sysRxValid = 1'b0; sysRxLast = 1'b0; curIsReadD = 1'b0;
  endtask

  task automatic sendPacket(input int maxGap);
    for (int i = 0; i < pw.size(); i++) begin
      logic isRd;
      isRd = (i >= 2) && (i % 2 == 0) && !pw[i-1][31];
      sendWord(pw[i], pb[i], i == pw.size() - 1, isRd);
      if (maxGap > 0) waitCycles($urandom_range(0, maxGap));
    end
  endtask

  // packet-level reference: what the reply and register writes must be
  task automatic model();
    expTx.delete(); expWr.delete(); expDrop = 1'b0;
    if (pb[0] != 2'd3) begin
      expDrop = 1'b1;
      return;
    end
    expTx.push_back(pw[0]);
    for (int i = 1; i < pw.size(); i += 2) begin
      if (i + 1 >= pw.size()) begin
        if (pb[i] != 2'd3) expDrop = 1'b1;
        break;
      end
      if (pb[i] != 2'd3 || pb[i+1] != 2'd3) begin
        expDrop = 1'b1;
        break;
      end
      if (expTx.size() + 2 > CAP) begin
        expDrop = 1'b1;
        break;
      end
      expTx.push_back(pw[i]);
      if (pw[i][31]) begin
        expTx.push_back(pw[i+1]);
        expWr.push_back({pw[i][23:0], pw[i+1]});
      end else begin
        expTx.push_back(rdFn(pw[i][23:0]));
      end
    end
  endtask

  task automatic clearObs();
    txQ.delete(); startQ.delete(); wrQ.delete();
  endtask

  task automatic runAndCompare(input string tag, input int maxGap);
    int n;
    clearObs();
    model();
    sendPacket(maxGap);
    waitCycles(20);
    check({tag, "_txcount"}, txQ.size(), expTx.size());
    n = (txQ.size() < expTx.size()) ? txQ.size() : expTx.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_tx%0d", tag, i), txQ[i], expTx[i]);
    if (expTx.size() > 0) begin
      check({tag, "_startcount"}, startQ.size(), 1);
      if (startQ.size() > 0)
        check({tag, "_startword"}, startQ[0], 32'((4 * expTx.size() - 1) << 16));
      expPackets++;
    end else begin
      check({tag, "_nostart"}, startQ.size(), 0);
    end
    if (expDrop) expDrops++;
    check({tag, "_wrcount"}, wrQ.size(), expWr.size());
    n = (wrQ.size() < expWr.size()) ? wrQ.size() : expWr.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_wr%0d", tag, i), wrQ[i], expWr[i]);
  endtask

  task automatic checkOutputsZero(input string tag);
    check({tag, "_ctrl"}, {sysRxEnable, sysRxReady, sysTxStrobe, sysTxStart, sysRegStrobe}, 5'b0);
    check({tag, "_txdata"}, sysTxData, 32'h0);
    check({tag, "_regaddr"}, sysRegAddr, 24'h0);
    check({tag, "_wrdata"}, sysRegWrData, 32'h0);
  endtask

  initial begin
    int readyHigh;
    sysReset_n = 1'b0; sysRxValid = 1'b0; sysRxLast = 1'b0; sysByteIndex = 2'd0;
    sysRxData = '0; sysTxBusy = 1'b0;
    repeat (3) @(negedge sysClk);
    checkOutputsZero("reset");
    #2 sysReset_n = 1'b1;
    #1 check("rxen_before_edge", sysRxEnable, 1'b0);
    @(negedge sysClk);
    check("rxen_after_edge", sysRxEnable, 1'b1);
    waitCycles(1);

    // write command
    pw = '{32'hCAFE0001, 32'h80000010, 32'h12345678}; pb = '{3, 3, 3};
    runAndCompare("write", 0);
    check("write_startword_abs", (startQ.size() > 0) ? startQ[0] : 32'hFFFF_FFFF, 32'h000B0000);

    // read command
    pw = '{$urandom(), 32'h00000020, $urandom()}; pb = '{3, 3, 3};
    runAndCompare("read", 0);

    // header + address only
    pw = '{32'h11112222, 32'h80000044}; pb = '{3, 3};
    runAndCompare("aonly", 0);

    // partial header, last
    pw = '{32'hABCD0000}; pb = '{1};
    runAndCompare("partial_hdr", 0);

    // transmitter busy holds off the receiver
    sysTxBusy = 1'b1; sysRxValid = 1'b1; sysRxData = 32'h5555AAAA; sysByteIndex = 2'd3;
    readyHigh = 0;
    repeat (10) begin
      @(negedge sysClk);
      if (sysRxReady) readyHigh++;
    end
    check("busy_ready_low", readyHigh, 0);
    waitCycles(1);
    sysTxBusy = 1'b0;
    pw = '{32'h5555AAAA, 32'h00000123, 32'h0, 32'h80000456, 32'h0BADF00D};
    pb = '{3, 3, 3, 3, 3};
    runAndCompare("after_busy", 0);

    // random packets
    for (int p = 0; p < 16; p++) begin
      int nPairs;
      pw.delete(); pb.delete();
      pw.push_back($urandom()); pb.push_back(2'd3);
      nPairs = $urandom_range(0, 4);
      for (int k = 0; k < nPairs; k++) begin
        pw.push_back({1'($urandom_range(0, 1)), 7'b0, 24'($urandom())}); pb.push_back(2'd3);
        pw.push_back($urandom()); pb.push_back(2'd3);
      end
      if ($urandom_range(0, 3) == 0) begin
        pw.push_back({1'($urandom_range(0, 1)), 7'b0, 24'($urandom())}); pb.push_back(2'd3);
      end
      if ($urandom_range(0, 4) == 0) pb[$urandom_range(0, pb.size() - 1)] = 2'($urandom_range(0, 2));
      runAndCompare($sformatf("rand%0d", p), 2);
    end

    // capacity truncation
    pw.delete(); pb.delete();
    pw.push_back(32'hC0FFEE00); pb.push_back(2'd3);
    for (int k = 0; k < 257; k++) begin
      pw.push_back({1'(k % 2), 7'b0, 24'(k * 16)}); pb.push_back(2'd3);
      pw.push_back($urandom()); pb.push_back(2'd3);
    end
    runAndCompare("capacity", 0);

    check("no_tx_while_busy", busyViol, 0);
`ifdef UDP_RESP_STATS_EN
    check("stat_packets", statPackets, 16'(expPackets));
    check("stat_drops", statDrops, 16'(expDrops));
`endif

    // reset in the middle of a command pair
    sendWord(32'h77770000, 2'd3, 1'b0, 1'b0);
    sendWord(32'h80000099, 2'd3, 1'b0, 1'b0);
    waitCycles(2);
    check("mid_ready_before_rst", sysRxReady, 1'b1);
    #2 sysReset_n = 1'b0;
    #1 checkOutputsZero("midreset");
`ifdef UDP_RESP_STATS_EN
    check("midreset_stats", {statPackets, statDrops}, 32'h0);
`endif
    expPackets = 0; expDrops = 0;
    #3 sysReset_n = 1'b1;
    waitCycles(2);
    pw = '{32'h600DCAFE, 32'h80000077, 32'h01020304, 32'h00000078, 32'h0};
    pb = '{3, 3, 3, 3, 3};
    runAndCompare("after_reset", 0);
`ifdef UDP_RESP_STATS_EN
    check("stat_packets_end", statPackets, 16'(expPackets));
    check("stat_drops_end", statDrops, 16'(expDrops));
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
